// File: rtl/sm_control_mc.sv
// Multicycle control FSM for the unified-memory schoolMIPS core: sequences the
// shared ALU, single-port memory and register file, with a stalled-memory watchdog.
module sm_control_mc #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] cmdOper,
  input  logic [5:0] cmdFunk,
  input  logic       aluZero,
  input  logic       memReady,
  output logic       memReq,
  output logic       iOrD,
  output logic       memWrite,
  output logic       irWrite,
  output logic       mdrWrite,
  output logic       pcWrite,
  output logic       pcSrc,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluControl,
  output logic       regDst,
  output logic       regWrite,
  output logic       memToReg,
  output logic       illegal,
  output logic       busErr,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WB   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ALU_WB   = 4'd9;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_LUI  = 3'b010;
  localparam logic [2:0] ALU_SRL  = 3'b011;
  localparam logic [2:0] ALU_SLTU = 3'b100;
  localparam logic [2:0] ALU_SUBU = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [TIMEOUT_W-1:0] WD_ONES = '1;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_ONES - TIMEOUT_W'(1);

  logic [3:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

  logic       memReq_c, iOrD_c, memWrite_c, irWrite_c, mdrWrite_c, pcWrite_c, pcSrc_c;
  logic       aluSrcA_c, regDst_c, regWrite_c, memToReg_c, illegal_c, busErr_c;
  logic [1:0] aluSrcB_c;
  logic [2:0] aluControl_c;
  logic       timeout;
  logic       rtype_ok;

  // The stalled cycle that would bring the watchdog to all-ones is the timeout cycle.
  assign timeout = (wdog_q == WD_LAST) && !memReady;

  always_comb begin
    rtype_ok = 1'b0;
    case (cmdFunk)
      FN_ADDU, FN_OR, FN_SRL, FN_SLTU, FN_SUBU: rtype_ok = 1'b1;
      default:                                  rtype_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    memReq_c     = 1'b0;
    iOrD_c       = 1'b0;
    memWrite_c   = 1'b0;
    irWrite_c    = 1'b0;
    mdrWrite_c   = 1'b0;
    pcWrite_c    = 1'b0;
    pcSrc_c      = 1'b0;
    aluSrcA_c    = 1'b0;
    aluSrcB_c    = 2'b00;
    aluControl_c = ALU_ADD;
    regDst_c     = 1'b0;
    regWrite_c   = 1'b0;
    memToReg_c   = 1'b0;
    illegal_c    = 1'b0;
    busErr_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        memReq_c  = 1'b1;
        aluSrcB_c = 2'b01;
        if (memReady) begin
          irWrite_c = 1'b1;
          pcWrite_c = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        aluSrcB_c = 2'b10;
        case (cmdOper)
          OP_RTYPE: begin
            if (rtype_ok) state_d = S_EXEC_R;
            else begin
              illegal_c = 1'b1;
              state_d   = S_FETCH;
            end
          end
          OP_ADDIU, OP_LUI: state_d = S_EXEC_I;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        aluSrcA_c = 1'b1;
        case (cmdFunk)
          FN_OR:   aluControl_c = ALU_OR;
          FN_SRL:  aluControl_c = ALU_SRL;
          FN_SLTU: aluControl_c = ALU_SLTU;
          FN_SUBU: aluControl_c = ALU_SUBU;
          default: aluControl_c = ALU_ADD;
        endcase
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        aluSrcA_c    = 1'b1;
        aluSrcB_c    = 2'b10;
        aluControl_c = (cmdOper == OP_LUI) ? ALU_LUI : ALU_ADD;
        state_d      = S_ALU_WB;
      end
      S_ALU_WB: begin
        regWrite_c = 1'b1;
        regDst_c   = (cmdOper == OP_RTYPE);
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        aluSrcA_c = 1'b1;
        aluSrcB_c = 2'b10;
        state_d   = (cmdOper == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        memReq_c = 1'b1;
        iOrD_c   = 1'b1;
        if (memReady) begin
          mdrWrite_c = 1'b1;
          state_d    = S_MEM_WB;
        end else if (timeout) begin
          busErr_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_MEM_WB: begin
        regWrite_c = 1'b1;
        memToReg_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        memReq_c   = 1'b1;
        memWrite_c = 1'b1;
        iOrD_c     = 1'b1;
        if (memReady) state_d = S_FETCH;
        else if (timeout) begin
          busErr_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_BRANCH: begin
        aluSrcA_c    = 1'b1;
        aluControl_c = ALU_SUBU;
        pcSrc_c      = 1'b1;
        pcWrite_c    = (cmdOper == OP_BEQ) ? aluZero : !aluZero;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // A fetch timeout clears the counter but keeps FETCH, which amounts to a silent retry.
  always_comb begin
    wdog_d = '0;
    if (memReq_c && !memReady && (state_d == state_q) && (wdog_q != WD_LAST))
      wdog_d = wdog_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  // Outputs are forced low combinationally so reset silences them without waiting for a clock.
  assign {memReq, iOrD, memWrite, irWrite, mdrWrite, pcWrite, pcSrc, aluSrcA,
          aluSrcB, aluControl, regDst, regWrite, memToReg, illegal, busErr} =
         rst_n ? {memReq_c, iOrD_c, memWrite_c, irWrite_c, mdrWrite_c, pcWrite_c,
                  pcSrc_c, aluSrcA_c, aluSrcB_c, aluControl_c, regDst_c, regWrite_c,
                  memToReg_c, illegal_c, busErr_c} : '0;
  assign state = state_q;

endmodule

// File: doc/sm_control_mc.md
Name: sm_control_mc

Overview:
- Multicycle control FSM for the unified-memory variant of the schoolMIPS core.
- Sequences one shared ALU, one single-port instruction/data memory and the register file through fetch, decode, execute, memory and writeback steps.
- The datapath provides the IR, ALUOut, MDR and PC registers plus the selection muxes; this block drives only their enables and selects.
- It also owns the memory request handshake and a watchdog for stalled memory.

Parameters:
TIMEOUT_W, 8, width of memory watchdog counter; timeout fires after 2^TIMEOUT_W-1 consecutive non-ready request cycles

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
cmdOper  input  6  IR[31:26] (registered instruction)
cmdFunk  input  6  IR[5:0]
aluZero  input  1  ALU zero flag
memReady  input  1  memory completes current request this cycle
memReq  output  1  memory access request
iOrD  output  1  memory address select: 0 = PC, 1 = ALUOut
memWrite  output  1  write strobe; valid only together with memReq
irWrite  output  1  load IR from memory read data
mdrWrite  output  1  load MDR from memory read data
pcWrite  output  1  load PC
pcSrc  output  1  PC source: 0 = ALU result, 1 = ALUOut
aluSrcA  output  1  0 = PC, 1 = rd1
aluSrcB  output  2  00 = rd2, 01 = constant 1, 10 = signImm
aluControl  output  3  ALU_* codes from sm_cpu.vh
regDst  output  1  1 = instr[15:11], 0 = instr[20:16]
regWrite  output  1  register file write enable
memToReg  output  1  writeback source: 1 = MDR, 0 = ALUOut
illegal  output  1  one-cycle pulse on an undecodable instruction
busErr  output  1  one-cycle pulse on a data-access timeout
state  output  4  current state code, for debug

Behaviour:
- State register is the only sequential element besides the watchdog.
- Async reset sets state to FETCH and clears the watchdog.
- While rst_n = 0, every output is 0 except state, which reads FETCH (code 0).
- Defaults in every state: all enables 0, aluSrcA = 0, aluSrcB = 00, aluControl = ALU_ADD.
- State codes: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, ALU_WB=9.
- FETCH
  - Outputs: memReq = 1, iOrD = 0, aluSrcA = PC, aluSrcB = 01, ALU_ADD.
  - If memReady: irWrite = 1, pcWrite = 1, pcSrc = 0, next = DECODE.
  - Otherwise hold in FETCH. A fetch timeout only clears the watchdog and retries; no busErr.
- DECODE
  - Outputs: aluSrcA = PC, aluSrcB = 10, ALU_ADD. ALUOut then holds the branch target PC+1+imm, because PC was already incremented.
  - Opcode 0x00 with funct ADDU 0x21, OR 0x25, SRL 0x02, SLTU 0x2B or SUBU 0x23 -> EXEC_R.
  - ADDIU 0x09 or LUI 0x0F -> EXEC_I.
  - LW 0x23 or SW 0x2B -> MEM_ADDR.
  - BEQ 0x04 or BNE 0x05 -> BRANCH.
  - Anything else -> FETCH with illegal = 1 for one cycle; no other side effect.
- EXEC_R
  - Outputs: aluSrcA = 1, aluSrcB = 00.
  - aluControl: ADD, OR, SRL, SLTU, SUBU according to funct.
  - Next = ALU_WB.
- EXEC_I
  - Outputs: aluSrcA = 1, aluSrcB = 10.
  - aluControl = ALU_ADD for ADDIU, ALU_LUI for LUI.
  - Next = ALU_WB.
- ALU_WB
  - Outputs: regWrite = 1, memToReg = 0.
  - regDst = 1 when opcode is 0x00, else 0.
  - Next = FETCH.
- MEM_ADDR
  - Outputs: aluSrcA = 1, aluSrcB = 10, ALU_ADD.
  - Next = MEM_RD for LW, MEM_WR for SW.
- MEM_RD
  - Outputs: memReq = 1, iOrD = 1.
  - If memReady: mdrWrite = 1, next = MEM_WB.
- MEM_WB
  - Outputs: regWrite = 1, memToReg = 1, regDst = 0.
  - Next = FETCH.
- MEM_WR
  - Outputs: memReq = 1, memWrite = 1, iOrD = 1.
  - If memReady: next = FETCH.
  - memWrite stays asserted, with the address held, until memReady.
- BRANCH
  - Outputs: aluSrcA = 1, aluSrcB = 00, ALU_SUBU, pcSrc = 1.
  - pcWrite = aluZero for BEQ, ~aluZero for BNE.
  - Next = FETCH.
- Watchdog
  - Increments each cycle memReq = 1 and memReady = 0; clears on any other cycle or on a state change.
  - In MEM_RD or MEM_WR, on reaching all-ones: busErr = 1 for one cycle, next = FETCH, no register or MDR update.
  - A memReady arriving in the same cycle as the timeout wins: normal completion, no busErr.
- Instruction latency with zero wait states: R-type and I-type ALU 4 cycles, LW 5, SW 4, branch 3. Each wait cycle adds 1.
- Reset asserted mid-instruction aborts it immediately; no write enable is asserted after reset rises.

Test Plan:
- memReady tied 1, IR = addu $3,$1,$2 (0x00221821) -> states 0,1,2,9,0. regWrite high only in state 9 with regDst = 1; pcWrite only in FETCH.
- lw 0x8C220004, memReady low for 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles; mdrWrite pulses once; MEM_WB has memToReg = 1; 8 cycles total.
- beq (0x10220003) with aluZero = 1, then again with aluZero = 0 -> BRANCH pcWrite = 1, pcSrc = 1 in the first case; pcWrite = 0 in the second.
- bne with aluZero = 0 -> pcWrite = 1; same instruction with aluZero = 1 -> pcWrite = 0.
- Opcode 0x3F -> illegal pulses once in DECODE, next state FETCH, no regWrite/memWrite.
- TIMEOUT_W = 2, sw with memReady held 0 -> memWrite held 3 cycles, busErr pulse, return to FETCH. Repeat with memReady = 1 on the 3rd cycle -> no busErr.
- rst_n dropped during MEM_WR -> all outputs 0 and state = 0 asynchronously. After release, the first cycle is FETCH with memReq = 1.
